// File: rtl/rv_skid_stage.sv
// rv_skid_stage: two-entry valid/ready skid buffer; every output is decoded from state flops.
// Latency: din accepted on edge N is on dout after edge N; sustains one transfer per cycle.
// Backpressure: in_ready drops only when both entries are held; the skid reg absorbs one stalled beat.
module rv_skid_stage #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  // State encoding doubles as the held-entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;
  logic             load_main_din;
  logic             load_main_skid;
  logic             load_skid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus the datapath load enables that go with each transition.
  always_comb begin
    state_d        = state_q;
    load_main_din  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d       = ST_BUSY;
          load_main_din = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_fire && !out_fire) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (!in_fire && out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire && out_fire) begin
          load_main_din = 1'b1;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the consumer side can move.
        if (out_fire) begin
          state_d        = ST_BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over everything; any beat accepted this cycle is dropped.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // Output decode: purely from flops so nothing combinational reaches the ports from inputs.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = (state_q != ST_FULL);
    count     = state_q;
    dout      = main_q;
  end

  // Payload registers; contents are left alone on flush since out_valid masks them.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if (load_main_din) begin
        main_q <= din;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= din;
      end
    end
  end

  // Structural invariants of the two-entry buffer.
  a_count_legal: assert property (@(posedge clk) disable iff (!rst_l) count != 2'd3);
  a_ready_full:  assert property (@(posedge clk) disable iff (!rst_l) !in_ready |-> (state_q == ST_FULL));
  a_valid_count: assert property (@(posedge clk) disable iff (!rst_l) out_valid |-> (count != 2'd0));

endmodule

// File: tb/tb_rv_skid_stage.sv
// Bench for rv_skid_stage: directed stall/flush/reset vectors plus random valid/ready traffic.
// Accepted beats are queued as the expected output; a negedge monitor pops and compares on out_fire.
// Stimulus changes 1 time unit after posedge; the monitor samples on negedge.
module tb_rv_skid_stage;

  localparam int W = 33;

  logic         clk;
  logic         rst_l;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic [1:0]   count;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  rv_skid_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on each negedge the inputs for the coming edge are settled, so fires are known.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_dout  = '0;
  always @(negedge clk) begin
    if (!rst_l) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        chk("stall_hold", 64'(dout), 64'(prev_dout));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_empty actual=%0h expected=none", dout);
        end else begin
          chk("scoreboard", 64'(dout), 64'(exp_q.pop_front()));
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back(din);
      end
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [31:0] r;
    rst_l     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_dout",      64'(dout),      64'd0);
    step();
    step();
    rst_l = 1'b1;

    // Streaming at full rate: each beat is on dout right after its accepting edge.
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1;
      din      = W'(k);
      step();
      chk("stream_dout",  64'(dout),      64'(k));
      chk("stream_count", 64'(count),     64'd1);
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", 64'(count), 64'd0);

    // Simultaneous fire while BUSY with the tag bit set: count stays 1, dout advances.
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 33'h1_0000_0000 | W'(k * 3 + 7);
      step();
      chk("both_dout",  64'(dout),  64'h1_0000_0000 | 64'(k * 3 + 7));
      chk("both_count", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    step();

    // Consumer stall fills the skid register; release drains both in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din       = 33'h1_AAAA_5555;
    step();
    chk("stall_count1", 64'(count), 64'd1);
    din = 33'h0_1234_5678;
    step();
    chk("stall_count2", 64'(count),    64'd2);
    chk("stall_ready",  64'(in_ready), 64'd0);
    chk("stall_dout",   64'(dout),     64'h1_AAAA_5555);
    in_valid = 1'b0;
    step();
    chk("stall_dout_hold", 64'(dout), 64'h1_AAAA_5555);
    out_ready = 1'b1;
    step();
    chk("release_dout",  64'(dout),  64'h0_1234_5678);
    chk("release_count", 64'(count), 64'd1);
    step();
    chk("release_empty", 64'(out_valid), 64'd0);

    // Flush while FULL with a new beat offered: everything is discarded.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din       = 33'h0_0000_00A1;
    step();
    din = 33'h1_0000_00B2;
    step();
    chk("preflush_count", 64'(count), 64'd2);
    flush = 1'b1;
    din   = 33'h0_0000_00C3;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 64'(count),     64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step();
    step();
    chk("flush_no_emit", 64'(out_valid), 64'd0);

    // Mid-traffic reset from FULL: outputs clear immediately, without an edge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din       = 33'h1_DEAD_BEEF;
    step();
    din = 33'h0_CAFE_F00D;
    step();
    chk("prerst_count", 64'(count), 64'd2);
    #2;
    rst_l    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_dout",  64'(dout),      64'd0);
    chk("midrst_ready", 64'(in_ready),  64'd1);
    chk("midrst_count", 64'(count),     64'd0);
    step();
    rst_l    = 1'b1;
    in_valid = 1'b1;
    din      = 33'h1_0F0F_0F0F;
    step();
    chk("first_accept_count", 64'(count), 64'd1);
    chk("first_accept_dout",  64'(dout),  64'h1_0F0F_0F0F);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("first_accept_drain", 64'(count), 64'd0);

    // Random valid/ready traffic; the monitor checks order, tag bit and hold behaviour.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      r         = $urandom;
      din       = {r[0], 32'($urandom)};
      step();
    end

    // Drain and confirm nothing was lost.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    #1;
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_count", 64'(count),        64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
